// File: rtl/div_clock_multi_pkg.sv
// Shared PWM types: enable/mode enums and the default divider width.
// Used by div_clock_chan and div_clock_multi.
package PKG_pwm;

    typedef enum logic {PWM_OFF = 1'b0, PWM_ON = 1'b1} _pwm_onoff;
    typedef enum logic {DIV_TOGGLE = 1'b0, DIV_PULSE = 1'b1} _div_mode;

    localparam int DIV_WIDTH_DEF = 16;

endpackage

// File: rtl/div_clock_chan.sv
// One divider channel: counter, optional shadow divider, registered clock/tick outputs.
// Macro DIVCLK_SHADOW_EN: when defined the divider is only sampled at wrap, sync or while off.
module div_clock_chan
    import PKG_pwm::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  _pwm_onoff            i_onoff,
    input  logic [DIV_WIDTH-1:0] i_divider,
    input  _div_mode             i_mode,
    input  logic                 i_sync,
    output logic                 o_div_clk,
    output logic                 o_div_tick,
    output logic [DIV_WIDTH-1:0] o_div_active
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_div_clk;
    logic                 r_div_tick;
    logic [DIV_WIDTH-1:0] w_div_act;
    logic                 w_restart;
    logic                 w_wrap;

    assign w_restart = (i_onoff == PWM_OFF) || i_sync;
    // >= rather than == so a divider lowered below the running count still wraps.
    assign w_wrap    = (r_cnt >= w_div_act);

`ifdef DIVCLK_SHADOW_EN
    logic [DIV_WIDTH-1:0] r_div_act;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_act <= '0;
        end else if (w_restart || w_wrap) begin
            r_div_act <= i_divider;
        end
    end

    assign w_div_act = r_div_act;
`else
    assign w_div_act = i_divider;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_div_clk  <= 1'b0;
            r_div_tick <= 1'b0;
        end else if (w_restart) begin
            r_cnt      <= '0;
            r_div_clk  <= 1'b0;
            r_div_tick <= 1'b0;
        end else if (w_wrap) begin
            r_cnt      <= '0;
            r_div_tick <= 1'b1;
            r_div_clk  <= (i_mode == DIV_TOGGLE) ? ~r_div_clk : 1'b1;
        end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_div_tick <= 1'b0;
            if (i_mode == DIV_PULSE) begin
                r_div_clk <= 1'b0;
            end
        end
    end

    assign o_div_clk    = r_div_clk;
    assign o_div_tick   = r_div_tick;
    assign o_div_active = w_div_act;

endmodule

// File: rtl/div_clock_multi.sv
// N_CH independent clock dividers sharing one phase-alignment sync strobe.
// Macro DIVCLK_SHADOW_EN selects shadowed (period-boundary) divider updates.
module div_clock_multi
    import PKG_pwm::*;
#(
    parameter int N_CH      = 4,
    parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  _pwm_onoff [N_CH-1:0]        pwm_onoff,
    input  logic [N_CH*DIV_WIDTH-1:0]   divider,
    input  _div_mode  [N_CH-1:0]        mode,
    input  logic                        sync,
    output logic [N_CH-1:0]             div_clk,
    output logic [N_CH-1:0]             div_tick,
    output logic [N_CH*DIV_WIDTH-1:0]   div_active
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        div_clock_chan #(
            .DIV_WIDTH (DIV_WIDTH)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .i_onoff      (pwm_onoff[g]),
            .i_divider    (divider[g*DIV_WIDTH +: DIV_WIDTH]),
            .i_mode       (mode[g]),
            .i_sync       (sync),
            .o_div_clk    (div_clk[g]),
            .o_div_tick   (div_tick[g]),
            .o_div_active (div_active[g*DIV_WIDTH +: DIV_WIDTH])
        );
    end

endmodule
